gshare_pht: RTL and testbench
=============================

Name: gshare_pht

Overview:
- Gshare pattern history table. It is the read side of the global history: it consumes the GHR bits and the fetch PC and returns a taken/not-taken prediction to fetch.
- It accepts resolved-branch updates from EX, using the table index that was carried down the pipeline with the branch.
- It holds one 2-bit saturating counter per entry.
- It keeps branch and mispredict performance counters.

Parameters:
- HISTORY_WIDTH, 8, width of ghr_data_i. Legal range is 2 to INDEX_WIDTH.
- INDEX_WIDTH, 8, log2 of the table depth (256 entries).
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- pc_i  in  32  fetch PC of the instruction being predicted.
- ghr_data_i  in  HISTORY_WIDTH  current global history; LSB is the newest outcome.
- pred_taken_o  out  1  prediction for pc_i.
- pred_idx_o  out  INDEX_WIDTH  table index used for this prediction; carried to EX.
- update_en_i  in  1  a resolved conditional branch is present this cycle.
- update_idx_i  in  INDEX_WIDTH  pred_idx_o value captured at fetch for that branch.
- br_taken_i  in  1  actual branch outcome.
- pred_taken_i  in  1  prediction originally issued for that branch.
- mispredict_o  out  1  update_en_i & (br_taken_i != pred_taken_i); combinational.
- br_count_o  out  CNT_WIDTH  resolved branches since reset.
- mispred_count_o  out  CNT_WIDTH  mispredicted branches since reset.

Behaviour:
- Index: pred_idx_o = pc_i[INDEX_WIDTH+1:2] XOR {zeros, ghr_data_i}. History is zero-extended into the LSBs.
- Read: combinational. pred_taken_o = MSB of the effective counter at pred_idx_o. The prediction is valid in the same cycle pc_i is presented; there is no read latency.
- Counter encoding:
  - 00 strong not-taken
  - 01 weak not-taken
  - 10 weak taken
  - 11 strong taken
- Update: on a clock edge where update_en_i=1, counter[update_idx_i] changes as follows:
  - br_taken_i=1: increments, saturating at 11.
  - br_taken_i=0: decrements, saturating at 00.
- When update_en_i=0, no entry changes.
- Bypass (same-cycle hazard): when update_en_i=1 and update_idx_i == pred_idx_o, pred_taken_o uses the post-update counter value, not the stored one.
- Different indices updated and read in the same cycle are independent.
- Perf counters, on a clock edge with update_en_i=1:
  - br_count_o increments by 1.
  - mispred_count_o increments by 1 when mispredict_o=1.
  - Both saturate at all-ones; no wrap.
- Reset, on an edge with rst_i=1:
  - Every counter is set to 01 (weak not-taken).
  - br_count_o and mispred_count_o are set to 0.
  - Reset dominates a simultaneous update_en_i; that update is discarded.
- Combinational outputs during reset:
  - pred_taken_o = 0 after the first reset edge.
  - pred_idx_o follows its inputs.
  - mispredict_o follows its inputs.
- PC bits [1:0] and bits above INDEX_WIDTH+1 do not affect the index.
- No X on any output after the first reset edge, regardless of inputs.

Test Plan:
- Reset, then pc_i=0x0000_0040, ghr=0x00 → pred_idx_o=0x10, pred_taken_o=0; br_count_o=0, mispred_count_o=0.
- Update idx 0x10 taken twice, with pred_taken_i=0 both times → counter goes 01→10→11. Read at 0x10 then gives pred_taken_o=1. mispredict_o=1 on both updates; mispred_count_o=2, br_count_o=2.
- Saturation at idx 0x10:
  - Four further taken updates → counter stays 11.
  - Then one not-taken update → counter 10, pred_taken_o still 1.
  - Then a second not-taken update → counter 01, pred_taken_o=0.
- Aliasing: pc_i=0x0000_0040 with ghr=0x10 → idx 0x00; pc_i=0x0000_0000 with ghr=0x00 → idx 0x00. Both reads return the same entry's prediction.
- Bypass: idx 0x22 at 01; same cycle update_en_i=1, update_idx_i=0x22, br_taken_i=1 and read pred_idx_o=0x22 → pred_taken_o=1 in that cycle. With update at 0x23 instead, the read at 0x22 gives pred_taken_o=0.
- Reset mid-operation and saturation:
  - Assert rst_i with update_en_i=1 on the same edge → all entries read 01 and counts are 0.
  - Preload br_count_o to all-ones via force, then one update → br_count_o stays all-ones.

Source files
------------

// File: rtl/gshare_pht.sv
// gshare_pht: gshare pattern history table with branch/mispredict perf counters.
//
// Ports:
//   clk_i, rst_i        clock; synchronous active-high reset
//   pc_i, ghr_data_i    fetch PC and global history used to form the index
//   pred_taken_o        taken/not-taken prediction for pc_i (no read latency)
//   pred_idx_o          index used for the prediction, carried down to EX
//   update_en_i         resolved conditional branch present this cycle
//   update_idx_i        index captured at fetch for that branch
//   br_taken_i          actual outcome
//   pred_taken_i        prediction originally issued for that branch
//   mispredict_o        combinational mispredict flag for the update
//   br_count_o          resolved branches since reset (saturating)
//   mispred_count_o     mispredicted branches since reset (saturating)
module gshare_pht #(
    parameter int HISTORY_WIDTH = 8,
    parameter int INDEX_WIDTH   = 8,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [31:0]              pc_i,
    input  logic [HISTORY_WIDTH-1:0] ghr_data_i,
    output logic                     pred_taken_o,
    output logic [INDEX_WIDTH-1:0]   pred_idx_o,
    input  logic                     update_en_i,
    input  logic [INDEX_WIDTH-1:0]   update_idx_i,
    input  logic                     br_taken_i,
    input  logic                     pred_taken_i,
    output logic                     mispredict_o,
    output logic [CNT_WIDTH-1:0]     br_count_o,
    output logic [CNT_WIDTH-1:0]     mispred_count_o
);

    localparam int DEPTH = 1 << INDEX_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic                   en;
        logic [INDEX_WIDTH-1:0] idx;
        logic                   taken;
    } upd_req_t;

    logic [1:0]             pht [DEPTH];
    logic [INDEX_WIDTH-1:0] ghr_ext;
    logic [1:0]             upd_cur;
    logic [1:0]             upd_next;
    logic [1:0]             rd_cur;
    upd_req_t               upd;
    logic [CNT_WIDTH-1:0]   br_count_q;
    logic [CNT_WIDTH-1:0]   mispred_count_q;

    assign upd = '{en: update_en_i, idx: update_idx_i, taken: br_taken_i};

    // History is zero-extended into the LSBs of the index.
    always_comb begin
        ghr_ext = '0;
        ghr_ext[HISTORY_WIDTH-1:0] = ghr_data_i;
    end

    assign pred_idx_o = pc_i[INDEX_WIDTH+1:2] ^ ghr_ext;

    // Saturating 2-bit counter step for the entry being trained.
    always_comb begin
        upd_cur  = pht[upd.idx];
        upd_next = upd_cur;
        if (upd.taken) begin
            if (upd_cur != 2'b11) upd_next = upd_cur + 2'd1;
        end else begin
            if (upd_cur != 2'b00) upd_next = upd_cur - 2'd1;
        end
    end

    // Same-cycle write to the entry being read forwards the post-update value.
    // Reset discards the update, so the forward is suppressed too and the
    // prediction is forced low.
    always_comb begin
        rd_cur = pht[pred_idx_o];
        if (upd.en && (upd.idx == pred_idx_o)) rd_cur = upd_next;
        pred_taken_o = rst_i ? 1'b0 : rd_cur[1];
    end

    assign mispredict_o = update_en_i & (br_taken_i != pred_taken_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) pht[i] <= 2'b01;
        end else if (upd.en) begin
            pht[upd.idx] <= upd_next;
        end
    end

    // Perf counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else if (update_en_i) begin
            if (br_count_q != '1) br_count_q <= br_count_q + CNT_ONE;
            if (mispredict_o && (mispred_count_q != '1))
                mispred_count_q <= mispred_count_q + CNT_ONE;
        end
    end

    assign br_count_o      = br_count_q;
    assign mispred_count_o = mispred_count_q;

endmodule

// File: tb/tb_gshare_pht.sv
// Scoreboarded bench for gshare_pht: a driver pushes expected outputs from a
// behavioural table model; a monitor pops and compares on the falling edge.
module tb_gshare_pht;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [7:0]  ghr;
    logic        pred_taken;
    logic [7:0]  pred_idx;
    logic        uen;
    logic [7:0]  uidx;
    logic        bt;
    logic        pti;
    logic        mispred;
    logic [31:0] bc;
    logic [31:0] mc;

    gshare_pht #(.HISTORY_WIDTH(8), .INDEX_WIDTH(8), .CNT_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .pc_i(pc), .ghr_data_i(ghr),
        .pred_taken_o(pred_taken), .pred_idx_o(pred_idx),
        .update_en_i(uen), .update_idx_i(uidx), .br_taken_i(bt),
        .pred_taken_i(pti), .mispredict_o(mispred),
        .br_count_o(bc), .mispred_count_o(mc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  idx;
        logic        pt;
        logic        mp;
        logic [31:0] bc;
        logic [31:0] mc;
        int          tag;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: plain integer counter values 0..3, long counts.
    int     m_cnt [256];
    longint m_bc, m_mc;
    localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;

    function automatic int sat_step(int c, bit taken);
        if (taken) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    task automatic check1(string nm, int tag, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s tag=%0d actual=%h required=%h", nm, tag, act, req);
        end
    endtask

    // Monitor: combinational outputs are stable by the falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check1("pred_idx",      e.tag, {24'd0, pred_idx}, {24'd0, e.idx});
            check1("pred_taken",    e.tag, {31'd0, pred_taken}, {31'd0, e.pt});
            check1("mispredict",    e.tag, {31'd0, mispred}, {31'd0, e.mp});
            check1("br_count",      e.tag, bc, e.bc);
            check1("mispred_count", e.tag, mc, e.mc);
        end
    end

    // Called just after a rising edge: drives one cycle, pushes the expected
    // view of that cycle, then advances the model across the next edge.
    task automatic cyc(input bit r, input logic [31:0] p, input logic [7:0] g,
                       input bit ue, input logic [7:0] ui, input bit t,
                       input bit pt, input int tag);
        exp_t e;
        int   idx, c;
        bit   mp;
        rst = r; pc = p; ghr = g; uen = ue; uidx = ui; bt = t; pti = pt;
        idx = ((p >> 2) % 256) ^ g;
        mp  = ue && (t != pt);
        c   = m_cnt[idx];
        if (ue && (ui == idx)) c = sat_step(m_cnt[ui], t);
        e.idx = idx[7:0];
        e.pt  = r ? 1'b0 : (c >= 2);
        e.mp  = mp;
        e.bc  = m_bc[31:0];
        e.mc  = m_mc[31:0];
        e.tag = tag;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < 256; i++) m_cnt[i] = 1;
            m_bc = 0;
            m_mc = 0;
        end else if (ue) begin
            m_cnt[ui] = sat_step(m_cnt[ui], t);
            if (m_bc < CMAX) m_bc++;
            if (mp && m_mc < CMAX) m_mc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog tag=0 actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rp;
        logic [7:0]  rg, ru;
        bit          rue;
        rst = 1'b1; pc = '0; ghr = '0; uen = 1'b0; uidx = '0; bt = 1'b0; pti = 1'b0;
        // First reset edge, unchecked: model state is defined only afterwards.
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) m_cnt[i] = 1;
        m_bc = 0; m_mc = 0;

        cyc(0, 32'h40, 8'h00, 0, 8'h00, 0, 0, 1);          // idx 0x10, weak NT
        cyc(0, 32'h40, 8'h00, 1, 8'h10, 1, 0, 2);          // 01->10, mispredict
        cyc(0, 32'h40, 8'h00, 1, 8'h10, 1, 0, 3);          // 10->11
        cyc(0, 32'h40, 8'h00, 0, 8'h00, 0, 0, 4);          // read taken, counts 2/2
        for (int i = 0; i < 4; i++) cyc(0, 32'h40, 8'h00, 1, 8'h10, 1, 1, 5);
        cyc(0, 32'h40, 8'h00, 1, 8'h10, 0, 1, 6);          // 11->10 (bypass shows 10)
        cyc(0, 32'h40, 8'h00, 0, 8'h00, 0, 0, 7);          // still taken
        cyc(0, 32'h40, 8'h00, 1, 8'h10, 0, 1, 8);          // 10->01
        cyc(0, 32'h40, 8'h00, 0, 8'h00, 0, 0, 9);          // not taken
        cyc(0, 32'h00, 8'h00, 1, 8'h00, 1, 0, 10);         // train entry 0
        cyc(0, 32'h40, 8'h10, 0, 8'h00, 0, 0, 11);         // alias -> idx 0
        cyc(0, 32'h00, 8'h00, 0, 8'h00, 0, 0, 12);         // idx 0
        cyc(0, 32'hFFFF_F003, 8'h00, 0, 8'h00, 0, 0, 13);  // upper/low PC bits ignored
        cyc(0, 32'h88, 8'h00, 1, 8'h22, 1, 0, 14);         // bypass at 0x22
        cyc(0, 32'h8C, 8'h01, 1, 8'h23, 1, 0, 15);         // 0x22 read, 0x23 written
        cyc(1, 32'h88, 8'h00, 1, 8'h22, 1, 0, 16);         // reset beats update
        cyc(0, 32'h88, 8'h00, 0, 8'h00, 0, 0, 17);
        cyc(0, 32'h40, 8'h00, 0, 8'h00, 0, 0, 18);

        force dut.br_count_q = 32'hFFFF_FFFF;
        #1 release dut.br_count_q;
        m_bc = CMAX;
        cyc(0, 32'h40, 8'h00, 1, 8'h10, 0, 1, 19);         // saturate br_count
        cyc(0, 32'h40, 8'h00, 0, 8'h00, 0, 0, 20);

        for (int i = 0; i < 400; i++) begin
            rp  = $urandom;
            rg  = 8'($urandom);
            rue = ($urandom_range(0, 3) != 0);
            ru  = ($urandom_range(0, 2) == 0) ? (8'(rp >> 2) ^ rg) : 8'($urandom_range(0, 15));
            cyc(($urandom_range(0, 99) == 0), rp, rg, rue, ru,
                1'($urandom), 1'($urandom), 100 + i);
        end

        @(negedge clk); #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain tag=0 actual=%0d required=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
